// File: rtl/farbfeld_pkg.sv
// rtl/farbfeld_pkg.sv - shared types, RGB565 packing and dither constants for the framebuffer writer
package farbfeld_pkg;

   localparam int RB_SHIFT = 9;
   localparam int G_SHIFT  = 8;

   // 2x2 ordered-dither matrix {{0,2},{3,1}}, two bits per entry, indexed by {row[0], col[0]}
   localparam logic [7:0] BAYER_M = 8'b01_11_10_00;

   typedef logic [15:0] rgb565_t;

   // Address is carried at full parser width; the top presents only the low ADDR_W bits
   typedef struct packed {
      logic [31:0] addr;
      rgb565_t     data;
   } fb_entry_t;

   function automatic logic [1:0] bayer_at(input logic r0, input logic c0);
      logic [2:0] base;
      base = {r0, c0, 1'b0};
      return BAYER_M[base +: 2];
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic rgb565_t pack565(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      logic unused_low;
      unused_low = ^{r[10:0], g[9:0], b[10:0]};
      return {r[15:11], g[15:10], b[15:11]};
   endfunction

endpackage

// File: rtl/farbfeld_pix_fifo.sv
// rtl/farbfeld_pix_fifo.sv - show-ahead synchronous FIFO of framebuffer entries with flush
import farbfeld_pkg::*;

module farbfeld_pix_fifo #(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  fb_entry_t wdata,
   input  logic      pop,
   output fb_entry_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   fb_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic              do_pop, do_push;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // Head is forced to zero when empty so downstream sees a clean bus after reset or drain
   assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   // Pointer next-state: flush wins, otherwise independent push/pop advances
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PW'(1);
         if (do_pop)  rptr_d = rptr_q + PW'(1);
      end
   end

   // Pointer registers; reset empties the queue immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage write; contents need no reset because the head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/farbfeld_fb_writer.sv
// rtl/farbfeld_fb_writer.sv - clips, packs and queues parser pixels as framebuffer writes (option: FARBFELD_FB_DITHER_EN)
import farbfeld_pkg::*;

module farbfeld_fb_writer #(
   parameter int FB_W   = 640,
   parameter int FB_H   = 480,
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pixelready,
   input  logic [31:0]       row,
   input  logic [31:0]       col,
   input  logic [15:0]       red,
   input  logic [15:0]       green,
   input  logic [15:0]       blue,
   input  logic              clear,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              overflow,
   output logic [15:0]       clip_count
);

   logic        in_bounds;
   logic [31:0] lin_addr;
   logic [15:0] red_t, green_t, blue_t;
   logic        fifo_full, fifo_empty;
   logic        pop, push, drop_full, clip_hit;
   fb_entry_t   wentry, head;
   logic [31:0] unused_head_addr;
   logic        overflow_q, overflow_d;
   logic [15:0] clip_count_q, clip_count_d;

   assign in_bounds = (row < 32'(FB_H)) && (col < 32'(FB_W));
   assign lin_addr  = row * 32'(FB_W) + col;

`ifdef FARBFELD_FB_DITHER_EN
   logic [15:0] bay16;
   assign bay16   = {14'd0, bayer_at(row[0], col[0])};
   assign red_t   = sat_add16(red,   bay16 << RB_SHIFT);
   assign green_t = sat_add16(green, bay16 << G_SHIFT);
   assign blue_t  = sat_add16(blue,  bay16 << RB_SHIFT);
`else
   assign red_t   = red;
   assign green_t = green;
   assign blue_t  = blue;
`endif

   assign wentry.addr = lin_addr;
   assign wentry.data = pack565(red_t, green_t, blue_t);

   // A full FIFO still accepts when the head leaves in the same cycle; clear discards everything
   assign pop       = mem_valid && mem_ready;
   assign push      = !clear && pixelready && in_bounds && (!fifo_full || pop);
   assign drop_full = !clear && pixelready && in_bounds && fifo_full && !pop;
   assign clip_hit  = !clear && pixelready && !in_bounds;

   farbfeld_pix_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clear),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mem_valid        = !fifo_empty;
   assign mem_addr         = head.addr[ADDR_W-1:0];
   assign mem_data         = head.data;
   assign unused_head_addr = head.addr;
   assign overflow         = overflow_q;
   assign clip_count       = clip_count_q;

   // Status next-state: sticky overflow and saturating clip counter, both zeroed by clear
   always_comb begin
      overflow_d   = overflow_q;
      clip_count_d = clip_count_q;
      if (clear) begin
         overflow_d   = 1'b0;
         clip_count_d = '0;
      end else begin
         if (drop_full) overflow_d = 1'b1;
         if (clip_hit && (clip_count_q != 16'hFFFF)) clip_count_d = clip_count_q + 16'd1;
      end
   end

   // Status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q   <= 1'b0;
         clip_count_q <= '0;
      end else begin
         overflow_q   <= overflow_d;
         clip_count_q <= clip_count_d;
      end
   end

endmodule
